// File: rtl/transfer_reg_n_pkg.sv
// Shared definitions for the parametrised transfer register: shift-sequencer
// state encodings and the default 9-bit masks of the original TR block.
package transfer_reg_n_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tr_state_e;

    localparam int unsigned DEF_WIDTH = 9;
    localparam int unsigned DEF_CNT_W = 4;

    // TR8 is excluded from zero-sense; TR6..TR8 are protected in external mode
    localparam logic [8:0] DEF_ZERO_MASK = 9'b1_0111_1111;
    localparam logic [8:0] DEF_HOLD_MASK = 9'b0_1110_0000;

endpackage

// File: rtl/transfer_reg_n_if.sv
// Bus/handshake bundle between the BRA/BRB side and the transfer register.
interface transfer_reg_n_if #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned CNT_W = 4
) ();
    logic             load_a;
    logic             load_b;
    logic [WIDTH-1:0] bra;
    logic [WIDTH-1:0] brb;
    logic             clr;
    logic             exmv_n;
    logic             shift_start;
    logic [CNT_W-1:0] shift_count;
    logic             shift_dir;
    logic             sin;
    logic [WIDTH-1:0] tr;
    logic [WIDTH-1:0] trn;
    logic [WIDTH-1:0] trd;
    logic [WIDTH-1:0] trdn;
    logic             ss;
    logic             sout;
    logic             busy;
    logic             done;

    modport slave (
        input  load_a, load_b, bra, brb, clr, exmv_n,
               shift_start, shift_count, shift_dir, sin,
        output tr, trn, trd, trdn, ss, sout, busy, done
    );

    modport master (
        output load_a, load_b, bra, brb, clr, exmv_n,
               shift_start, shift_count, shift_dir, sin,
        input  tr, trn, trd, trdn, ss, sout, busy, done
    );
endinterface

// File: rtl/transfer_reg_n_shift_ctl.sv
// Shift sequencer: IDLE/SHIFT FSM with down-counter, latched direction and
// the BUSY level / one-cycle DONE pulse.
module tr_shift_ctl
    import transfer_reg_n_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             dir_i,
    input  logic             clr_i,
    input  logic             load_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             step_o,
    output logic             dir_o
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    tr_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    // Next-state: clear aborts a sequence, a load in the same cycle outranks a start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !clr_i && !load_i) begin
                    if (count_i != CNT_ZERO) begin
                        state_d = ST_SHIFT;
                        cnt_d   = count_i;
                        dir_d   = dir_i;
                    end else begin
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (clr_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == ST_SHIFT);
    assign step_o = (state_q == ST_SHIFT) && !clr_i;
    assign done_o = done_q;
    assign dir_o  = dir_q;
endmodule

// File: rtl/transfer_reg_n.sv
// WIDTH-bit transfer register: wired-OR dual-bus load, protected clear,
// delayed copy, masked zero-sense and a sequenced serial shifter.
module transfer_reg_n
    import transfer_reg_n_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter int unsigned      CNT_W     = DEF_CNT_W,
    parameter logic [WIDTH-1:0] ZERO_MASK = DEF_ZERO_MASK,
    parameter logic [WIDTH-1:0] HOLD_MASK = DEF_HOLD_MASK
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    transfer_reg_n_if.slave bus
);
    logic [WIDTH-1:0] tr_q, tr_d;
    logic [WIDTH-1:0] trd_q;
    logic             ss_q;
    logic             sout_q, sout_d;
    logic [WIDTH-1:0] hold_s;
    logic [WIDTH-1:0] load_val_s;
    logic             load_any_s;
    logic             busy_s, done_s, step_s, dir_s;

    tr_shift_ctl #(.CNT_W(CNT_W)) u_ctl (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (bus.shift_start),
        .count_i (bus.shift_count),
        .dir_i   (bus.shift_dir),
        .clr_i   (bus.clr),
        .load_i  (load_any_s),
        .busy_o  (busy_s),
        .done_o  (done_s),
        .step_o  (step_s),
        .dir_o   (dir_s)
    );

    assign load_any_s = bus.load_a | bus.load_b;

    // Register next value: clear > load (idle only) > shift step; shifts bypass protection
    always_comb begin
        hold_s     = bus.exmv_n ? {WIDTH{1'b0}} : HOLD_MASK;
        load_val_s = (bus.load_a ? bus.bra : {WIDTH{1'b0}})
                   | (bus.load_b ? bus.brb : {WIDTH{1'b0}});
        tr_d       = tr_q;
        sout_d     = sout_q;
        if (bus.clr) begin
            tr_d = tr_q & hold_s;
        end else if (load_any_s && !busy_s) begin
            tr_d = (tr_q & hold_s) | (load_val_s & ~hold_s);
        end else if (step_s) begin
            if (dir_s) begin
                tr_d   = {tr_q[WIDTH-2:0], bus.sin};
                sout_d = tr_q[WIDTH-1];
            end else begin
                tr_d   = {bus.sin, tr_q[WIDTH-1:1]};
                sout_d = tr_q[0];
            end
        end else begin
            tr_d = tr_q;
        end
    end

    // Datapath registers; TRD and SS both trail TR by one cycle
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tr_q   <= {WIDTH{1'b0}};
            trd_q  <= {WIDTH{1'b0}};
            ss_q   <= 1'b1;
            sout_q <= 1'b0;
        end else begin
            tr_q   <= tr_d;
            trd_q  <= tr_q;
            ss_q   <= ~|(tr_q & ZERO_MASK);
            sout_q <= sout_d;
        end
    end

    assign bus.tr   = tr_q;
    assign bus.trn  = ~tr_q;
    assign bus.trd  = trd_q;
    assign bus.trdn = ~trd_q;
    assign bus.ss   = ss_q;
    assign bus.sout = sout_q;
    assign bus.busy = busy_s;
    assign bus.done = done_s;
endmodule

// File: tb/tb_transfer_reg_n.sv
// Directed scoreboard bench for transfer_reg_n: expectations are queued with
// each stimulus step and checked one clock later.
module tb_transfer_reg_n;
    localparam int SEL_TR = 0, SEL_TRN = 1, SEL_TRD = 2, SEL_TRDN = 3;
    localparam int SEL_SS = 4, SEL_SOUT = 5, SEL_BUSY = 6, SEL_DONE = 7;

    typedef struct {
        string      tag;
        int         sel;
        logic [8:0] val;
    } exp_t;

    logic clk;
    logic rstn;
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    transfer_reg_n_if #(.WIDTH(9), .CNT_W(4)) bus ();

    transfer_reg_n dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] observe(int sel);
        case (sel)
            SEL_TR:   return bus.tr;
            SEL_TRN:  return bus.trn;
            SEL_TRD:  return bus.trd;
            SEL_TRDN: return bus.trdn;
            SEL_SS:   return {8'h00, bus.ss};
            SEL_SOUT: return {8'h00, bus.sout};
            SEL_BUSY: return {8'h00, bus.busy};
            SEL_DONE: return {8'h00, bus.done};
            default:  return 9'h000;
        endcase
    endfunction

    task automatic exp(input string tag, input int sel, input logic [8:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        logic [8:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.val)
            else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.load_a = 1'b0; bus.load_b = 1'b0;
        bus.bra = 9'h000;  bus.brb = 9'h000;
        bus.clr = 1'b0;    bus.exmv_n = 1'b1;
        bus.shift_start = 1'b0; bus.shift_count = 4'd0;
        bus.shift_dir = 1'b0;   bus.sin = 1'b0;
    endtask

    task automatic load(input logic [8:0] v);
        bus.load_a = 1'b1; bus.bra = v;
        tick();
        bus.load_a = 1'b0; bus.bra = 9'h000;
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        exp("rst_tr", SEL_TR, 9'h000);   exp("rst_trn", SEL_TRN, 9'h1FF);
        exp("rst_ss", SEL_SS, 9'h001);   exp("rst_busy", SEL_BUSY, 9'h000);
        exp("rst_done", SEL_DONE, 9'h000); exp("rst_trd", SEL_TRD, 9'h000);
        tick();

        // dual-bus wired-OR load
        bus.load_a = 1'b1; bus.bra = 9'h0A5;
        bus.load_b = 1'b1; bus.brb = 9'h150;
        exp("or_tr", SEL_TR, 9'h1F5); exp("or_trn", SEL_TRN, 9'h00A);
        tick();
        idle_inputs();
        exp("or_trd", SEL_TRD, 9'h1F5); exp("or_trdn", SEL_TRDN, 9'h00A);
        exp("or_ss", SEL_SS, 9'h000);
        tick();

        // only TR8 set: masked out of zero-sense
        load(9'h080);
        exp("tr8_ss", SEL_SS, 9'h001);
        tick();

        // right shift of 3 with SIN=1, load attempt while busy ignored
        load(9'h003);
        bus.shift_start = 1'b1; bus.shift_count = 4'd3; bus.shift_dir = 1'b0; bus.sin = 1'b1;
        exp("r3_busy0", SEL_BUSY, 9'h001); exp("r3_tr0", SEL_TR, 9'h003);
        tick();
        bus.shift_start = 1'b0;
        exp("r3_tr1", SEL_TR, 9'h101); exp("r3_sout1", SEL_SOUT, 9'h001);
        exp("r3_busy1", SEL_BUSY, 9'h001);
        tick();
        bus.load_a = 1'b1; bus.bra = 9'h1FF;
        exp("r3_tr2", SEL_TR, 9'h180); exp("r3_busy2", SEL_BUSY, 9'h001);
        exp("r3_done2", SEL_DONE, 9'h000);
        tick();
        bus.load_a = 1'b0; bus.bra = 9'h000;
        exp("r3_tr3", SEL_TR, 9'h1C0); exp("r3_sout3", SEL_SOUT, 9'h000);
        exp("r3_busy3", SEL_BUSY, 9'h000); exp("r3_done3", SEL_DONE, 9'h001);
        tick();
        exp("r3_done_end", SEL_DONE, 9'h000);
        tick();

        // protected clear and protected load in external mode
        load(9'h1FF);
        bus.exmv_n = 1'b0; bus.clr = 1'b1;
        exp("clr_ext", SEL_TR, 9'h0E0);
        tick();
        bus.exmv_n = 1'b1;
        exp("clr_norm", SEL_TR, 9'h000);
        tick();
        bus.clr = 1'b0; bus.exmv_n = 1'b0;
        bus.load_a = 1'b1; bus.bra = 9'h1FF;
        exp("load_ext", SEL_TR, 9'h11F);
        tick();
        idle_inputs();

        // left shift of 5 aborted by clear after two steps
        load(9'h0F0);
        bus.shift_start = 1'b1; bus.shift_count = 4'd5; bus.shift_dir = 1'b1; bus.sin = 1'b0;
        exp("l5_busy0", SEL_BUSY, 9'h001);
        tick();
        bus.shift_start = 1'b0;
        exp("l5_tr1", SEL_TR, 9'h1E0); exp("l5_sout1", SEL_SOUT, 9'h000);
        tick();
        exp("l5_tr2", SEL_TR, 9'h1C0); exp("l5_sout2", SEL_SOUT, 9'h001);
        tick();
        bus.clr = 1'b1;
        exp("abort_busy", SEL_BUSY, 9'h000); exp("abort_done", SEL_DONE, 9'h000);
        exp("abort_tr", SEL_TR, 9'h000); exp("abort_sout", SEL_SOUT, 9'h001);
        tick();
        bus.clr = 1'b0;
        exp("abort_done2", SEL_DONE, 9'h000); exp("abort_busy2", SEL_BUSY, 9'h000);
        tick();

        // zero-count start: immediate DONE, register held
        load(9'h055);
        bus.shift_start = 1'b1; bus.shift_count = 4'd0;
        exp("n0_done", SEL_DONE, 9'h001); exp("n0_busy", SEL_BUSY, 9'h000);
        exp("n0_tr", SEL_TR, 9'h055);
        tick();
        // restart accepted in the DONE cycle
        bus.shift_count = 4'd1; bus.shift_dir = 1'b0; bus.sin = 1'b0;
        exp("n1_busy", SEL_BUSY, 9'h001); exp("n1_done_lo", SEL_DONE, 9'h000);
        tick();
        bus.shift_start = 1'b0;
        exp("n1_tr", SEL_TR, 9'h02A); exp("n1_sout", SEL_SOUT, 9'h001);
        exp("n1_done", SEL_DONE, 9'h001);
        tick();
        bus.shift_start = 1'b1; bus.shift_dir = 1'b1; bus.sin = 1'b1;
        exp("b2b_busy", SEL_BUSY, 9'h001);
        tick();
        bus.shift_start = 1'b0;
        exp("b2b_tr", SEL_TR, 9'h055); exp("b2b_done", SEL_DONE, 9'h001);
        exp("b2b_sout", SEL_SOUT, 9'h000);
        tick();

        // reset in the middle of a sequence
        load(9'h1AA);
        bus.shift_start = 1'b1; bus.shift_count = 4'd4; bus.shift_dir = 1'b0; bus.sin = 1'b1;
        tick();
        bus.shift_start = 1'b0;
        tick();
        rstn = 1'b0;
        exp("mrst_tr", SEL_TR, 9'h000); exp("mrst_trd", SEL_TRD, 9'h000);
        exp("mrst_ss", SEL_SS, 9'h001); exp("mrst_sout", SEL_SOUT, 9'h000);
        exp("mrst_busy", SEL_BUSY, 9'h000); exp("mrst_done", SEL_DONE, 9'h000);
        tick();
        rstn = 1'b1;
        exp("mrst_done2", SEL_DONE, 9'h000); exp("mrst_busy2", SEL_BUSY, 9'h000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
